nram_writer: RTL and testbench

- Master-side controller for the two-entry NRAM register bank: it owns the write side of the bank (io_Dbus, io_ENbus) and consumes the read side (io_Qbus_0/1).
- Accepts write requests and read requests on ready/valid channels.
- Sequences each write as a single-cycle enable pulse, then read-back verifies it with bounded retries, and returns read data on an output stream.
- Sits between the control datapath and the NRAM instance; it is the only driver of the bank's write interface.

---
 rtl/nram_writer_if.sv | 40 ++++
 rtl/nram_writer.sv | 135 +++++++++++++
 tb/tb_nram_writer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/nram_writer_if.sv
// Request, response and NRAM-bank signals of the NRAM write controller.
// The slave modport is the controller's view; master is the requester/bank side.
interface nram_writer_if #(
  parameter int DATA_W = 8
);
  logic              io_wr_valid;
  logic              io_wr_ready;
  logic              io_wr_addr;
  logic [DATA_W-1:0] io_wr_data;
  logic              io_rd_valid;
  logic              io_rd_ready;
  logic              io_rd_addr;
  logic              io_out_valid;
  logic              io_out_ready;
  logic [DATA_W-1:0] io_out_bits;
  logic [DATA_W-1:0] io_Dbus;
  logic [1:0]        io_ENbus;
  logic [DATA_W-1:0] io_Qbus_0;
  logic [DATA_W-1:0] io_Qbus_1;
  logic              io_err;
  logic              io_err_clr;
  logic [7:0]        io_wr_count;
  logic              io_busy;

  modport slave (
    input  io_wr_valid, io_wr_addr, io_wr_data,
    input  io_rd_valid, io_rd_addr, io_out_ready,
    input  io_Qbus_0, io_Qbus_1, io_err_clr,
    output io_wr_ready, io_rd_ready, io_out_valid, io_out_bits,
    output io_Dbus, io_ENbus, io_err, io_wr_count, io_busy
  );

  modport master (
    output io_wr_valid, io_wr_addr, io_wr_data,
    output io_rd_valid, io_rd_addr, io_out_ready,
    output io_Qbus_0, io_Qbus_1, io_err_clr,
    input  io_wr_ready, io_rd_ready, io_out_valid, io_out_bits,
    input  io_Dbus, io_ENbus, io_err, io_wr_count, io_busy
  );
endinterface

// File: rtl/nram_writer.sv
// Write-side controller for the two-entry NRAM bank: single-cycle write pulses,
// read-back verify with bounded retries, and a read response stream.
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_IDLE     | ready for a write (priority) or read request
// S_WRITE    | one-cycle enable pulse to the latched entry
// S_VERIFY   | compare bank read-back against latched data, retry or flag
// S_READ_OUT | holding read response until downstream accepts it
module nram_writer #(
  parameter int DATA_W    = 8,
  parameter bit VERIFY_EN = 1'b1,
  parameter int RETRY_MAX = 2
) (
  input  logic         clk,
  input  logic         reset,
  nram_writer_if.slave bus
);

  localparam int RW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
  localparam logic [RW-1:0] RETRY_LIM = RW'(RETRY_MAX);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_VERIFY,
    S_READ_OUT
  } state_t;

  state_t            state_q, state_d;
  logic              addr_q;
  logic [DATA_W-1:0] data_q;
  logic [RW-1:0]     retry_q;
  logic [DATA_W-1:0] out_bits_q;
  logic              err_q;
  logic [7:0]        cnt_q;

  logic              wr_ready, rd_ready;
  logic              wr_fire, rd_fire;
  logic              retry_inc, err_set, cnt_inc;
  logic [DATA_W-1:0] q_latched;
  logic [DATA_W-1:0] q_requested;

  assign q_latched   = addr_q ? bus.io_Qbus_1 : bus.io_Qbus_0;
  assign q_requested = bus.io_rd_addr ? bus.io_Qbus_1 : bus.io_Qbus_0;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    wr_ready  = 1'b0;
    rd_ready  = 1'b0;
    wr_fire   = 1'b0;
    rd_fire   = 1'b0;
    retry_inc = 1'b0;
    err_set   = 1'b0;
    cnt_inc   = 1'b0;
    case (state_q)
      S_IDLE: begin
        wr_ready = 1'b1;
        rd_ready = !bus.io_wr_valid;
        if (bus.io_wr_valid) begin
          wr_fire = 1'b1;
          state_d = S_WRITE;
        end else if (bus.io_rd_valid) begin
          rd_fire = 1'b1;
          state_d = S_READ_OUT;
        end
      end
      S_WRITE: begin
        if (VERIFY_EN) begin
          state_d = S_VERIFY;
        end else begin
          cnt_inc = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_VERIFY: begin
        if (q_latched == data_q) begin
          cnt_inc = 1'b1;
          state_d = S_IDLE;
        end else if (retry_q < RETRY_LIM) begin
          retry_inc = 1'b1;
          state_d   = S_WRITE;
        end else begin
          err_set = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_READ_OUT: begin
        if (bus.io_out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // data_q doubles as the Dbus register so the bus holds its last value outside WRITE
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q     <= 1'b0;
      data_q     <= '0;
      retry_q    <= '0;
      out_bits_q <= '0;
      err_q      <= 1'b0;
      cnt_q      <= 8'd0;
    end else begin
      if (wr_fire) begin
        addr_q  <= bus.io_wr_addr;
        data_q  <= bus.io_wr_data;
        retry_q <= '0;
      end else if (retry_inc) begin
        retry_q <= retry_q + RW'(1);
      end
      if (rd_fire) out_bits_q <= q_requested;
      if (err_set)             err_q <= 1'b1;
      else if (bus.io_err_clr) err_q <= 1'b0;
      if (cnt_inc) cnt_q <= cnt_q + 8'd1;
    end
  end

  // Enable is gated by reset directly so a reset landing in WRITE never writes the bank
  assign bus.io_ENbus     = (state_q == S_WRITE && !reset) ? (addr_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.io_Dbus      = data_q;
  assign bus.io_wr_ready  = wr_ready;
  assign bus.io_rd_ready  = rd_ready;
  assign bus.io_out_valid = (state_q == S_READ_OUT);
  assign bus.io_out_bits  = out_bits_q;
  assign bus.io_err       = err_q;
  assign bus.io_wr_count  = cnt_q;
  assign bus.io_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_nram_writer.sv
// Bench for nram_writer: NRAM bank model, per-cycle vector table, and
// hand sequences for retries, count wrap and reset during a write.
module tb_nram_writer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  nram_writer_if #(.DATA_W(8)) bus ();

  nram_writer #(.DATA_W(8), .VERIFY_EN(1'b1), .RETRY_MAX(2)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Bank model; drop1 makes entry 1 ignore writes and read back 0x00
  logic [7:0] mem0 = 8'h00;
  logic [7:0] mem1 = 8'h00;
  logic       drop1 = 1'b0;
  always @(posedge clk) begin
    if (bus.io_ENbus[0]) mem0 <= bus.io_Dbus;
    if (bus.io_ENbus[1] && !drop1) mem1 <= bus.io_Dbus;
  end
  assign bus.io_Qbus_0 = mem0;
  assign bus.io_Qbus_1 = drop1 ? 8'h00 : mem1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       wv;  logic wa;  logic [7:0] wd;
    logic       rv;  logic ra;  logic ordy;
    logic       e_wrdy; logic e_rrdy; logic e_ov; logic [7:0] e_ob;
    logic [1:0] e_en;   logic [7:0] e_db; logic e_busy; logic [7:0] e_cnt;
  } vec_t;

  vec_t vecs[17];

  task automatic run_write(input logic a, input logic [7:0] d, input logic clr,
                           output int pulses, output int cycles);
    logic [1:0] oh;
    oh = a ? 2'b10 : 2'b01;
    bus.io_wr_valid = 1'b1;
    bus.io_wr_addr  = a;
    bus.io_wr_data  = d;
    bus.io_err_clr  = clr;
    @(posedge clk); #1;
    bus.io_wr_valid = 1'b0;
    bus.io_wr_data  = ~d;
    pulses = 0;
    cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!bus.io_busy) break;
      cycles++;
      if (bus.io_ENbus == oh && bus.io_Dbus == d) pulses++;
      @(posedge clk); #1;
    end
    check("write_done", {31'd0, bus.io_busy}, 32'd0);
  endtask

  int p, c, tot;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    //           wv wa wd    rv ra ordy wrdy rrdy ov ob     en     db     busy cnt
    vecs[0]  = '{0, 0, 8'h00, 0, 0, 0,  1,   1,   0, 8'h00, 2'b00, 8'h00, 0, 8'd0};
    vecs[1]  = '{1, 0, 8'hA5, 0, 0, 0,  1,   0,   0, 8'h00, 2'b00, 8'h00, 0, 8'd0};
    vecs[2]  = '{0, 0, 8'h00, 0, 0, 0,  0,   0,   0, 8'h00, 2'b01, 8'hA5, 1, 8'd0};
    vecs[3]  = '{0, 0, 8'h00, 0, 0, 0,  0,   0,   0, 8'h00, 2'b00, 8'hA5, 1, 8'd0};
    vecs[4]  = '{1, 1, 8'h3C, 1, 0, 0,  1,   0,   0, 8'h00, 2'b00, 8'hA5, 0, 8'd1};
    vecs[5]  = '{0, 0, 8'h00, 1, 0, 0,  0,   0,   0, 8'h00, 2'b10, 8'h3C, 1, 8'd1};
    vecs[6]  = '{0, 0, 8'h00, 1, 0, 0,  0,   0,   0, 8'h00, 2'b00, 8'h3C, 1, 8'd1};
    vecs[7]  = '{0, 0, 8'h00, 1, 0, 0,  1,   1,   0, 8'h00, 2'b00, 8'h3C, 0, 8'd2};
    vecs[8]  = '{0, 0, 8'h00, 0, 0, 1,  0,   0,   1, 8'hA5, 2'b00, 8'h3C, 1, 8'd2};
    vecs[9]  = '{0, 0, 8'h00, 1, 1, 0,  1,   1,   0, 8'hA5, 2'b00, 8'h3C, 0, 8'd2};
    vecs[10] = '{1, 0, 8'hEE, 1, 1, 0,  0,   0,   1, 8'h3C, 2'b00, 8'h3C, 1, 8'd2};
    vecs[11] = '{0, 0, 8'h00, 1, 0, 0,  0,   0,   1, 8'h3C, 2'b00, 8'h3C, 1, 8'd2};
    vecs[12] = '{0, 0, 8'h00, 1, 0, 0,  0,   0,   1, 8'h3C, 2'b00, 8'h3C, 1, 8'd2};
    vecs[13] = '{0, 0, 8'h00, 1, 0, 0,  0,   0,   1, 8'h3C, 2'b00, 8'h3C, 1, 8'd2};
    vecs[14] = '{0, 0, 8'h00, 1, 0, 0,  0,   0,   1, 8'h3C, 2'b00, 8'h3C, 1, 8'd2};
    vecs[15] = '{0, 0, 8'h00, 0, 0, 1,  0,   0,   1, 8'h3C, 2'b00, 8'h3C, 1, 8'd2};
    vecs[16] = '{0, 0, 8'h00, 0, 0, 0,  1,   1,   0, 8'h3C, 2'b00, 8'h3C, 0, 8'd2};

    reset = 1'b1;
    bus.io_wr_valid  = 1'b0;
    bus.io_wr_addr   = 1'b0;
    bus.io_wr_data   = 8'h00;
    bus.io_rd_valid  = 1'b0;
    bus.io_rd_addr   = 1'b0;
    bus.io_out_ready = 1'b0;
    bus.io_err_clr   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_dbus",     {24'd0, bus.io_Dbus}, 32'h00);
    check("rst_enbus",    {30'd0, bus.io_ENbus}, 32'h0);
    check("rst_out_valid",{31'd0, bus.io_out_valid}, 32'h0);
    check("rst_out_bits", {24'd0, bus.io_out_bits}, 32'h00);
    check("rst_err",      {31'd0, bus.io_err}, 32'h0);
    check("rst_count",    {24'd0, bus.io_wr_count}, 32'h0);
    check("rst_busy",     {31'd0, bus.io_busy}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      bus.io_wr_valid  = vecs[i].wv;
      bus.io_wr_addr   = vecs[i].wa;
      bus.io_wr_data   = vecs[i].wd;
      bus.io_rd_valid  = vecs[i].rv;
      bus.io_rd_addr   = vecs[i].ra;
      bus.io_out_ready = vecs[i].ordy;
      @(negedge clk);
      check($sformatf("v%0d_wr_ready", i),  {31'd0, bus.io_wr_ready}, {31'd0, vecs[i].e_wrdy});
      check($sformatf("v%0d_rd_ready", i),  {31'd0, bus.io_rd_ready}, {31'd0, vecs[i].e_rrdy});
      check($sformatf("v%0d_out_valid", i), {31'd0, bus.io_out_valid}, {31'd0, vecs[i].e_ov});
      check($sformatf("v%0d_out_bits", i),  {24'd0, bus.io_out_bits}, {24'd0, vecs[i].e_ob});
      check($sformatf("v%0d_enbus", i),     {30'd0, bus.io_ENbus}, {30'd0, vecs[i].e_en});
      check($sformatf("v%0d_dbus", i),      {24'd0, bus.io_Dbus}, {24'd0, vecs[i].e_db});
      check($sformatf("v%0d_busy", i),      {31'd0, bus.io_busy}, {31'd0, vecs[i].e_busy});
      check($sformatf("v%0d_count", i),     {24'd0, bus.io_wr_count}, {24'd0, vecs[i].e_cnt});
      check($sformatf("v%0d_err", i),       {31'd0, bus.io_err}, 32'd0);
      @(posedge clk); #1;
    end
    bus.io_rd_valid  = 1'b0;
    bus.io_out_ready = 1'b0;
    check("bank0_a5", {24'd0, bus.io_Qbus_0}, 32'hA5);

    // Entry 1 stuck: initial write plus two retries, then error
    drop1 = 1'b1;
    run_write(1'b1, 8'h77, 1'b0, p, c);
    check("retry_pulses", p, 3);
    check("retry_cycles", c, 6);
    check("retry_err",    {31'd0, bus.io_err}, 32'd1);
    check("retry_count",  {24'd0, bus.io_wr_count}, 32'd2);
    bus.io_err_clr = 1'b1;
    @(posedge clk); #1;
    bus.io_err_clr = 1'b0;
    @(negedge clk);
    check("err_cleared", {31'd0, bus.io_err}, 32'd0);

    // err_clr held through a failing write: the final set must win
    run_write(1'b1, 8'h12, 1'b1, p, c);
    bus.io_err_clr = 1'b0;
    check("set_wins_pulses", p, 3);
    check("set_wins_err", {31'd0, bus.io_err}, 32'd1);
    bus.io_err_clr = 1'b1;
    @(posedge clk); #1;
    bus.io_err_clr = 1'b0;
    @(negedge clk);
    check("err_cleared2", {31'd0, bus.io_err}, 32'd0);
    drop1 = 1'b0;

    // Count starts at 2: 253 writes reach 255, the 254th wraps to 0
    tot = 0;
    for (int i = 0; i < 254; i++) begin
      run_write(i[0], 8'(i + 3), 1'b0, p, c);
      tot += p;
      if (i == 252) check("count_255", {24'd0, bus.io_wr_count}, 32'd255);
    end
    check("wrap_pulses", tot, 254);
    check("count_wrap",  {24'd0, bus.io_wr_count}, 32'd0);
    check("wrap_err",    {31'd0, bus.io_err}, 32'd0);

    run_write(1'b0, 8'h99, 1'b0, p, c);
    check("clean_cycles", c, 2);
    check("clean_pulses", p, 1);
    check("bank0_99",     {24'd0, bus.io_Qbus_0}, 32'h99);
    check("count_1",      {24'd0, bus.io_wr_count}, 32'd1);

    // Reset lands in the WRITE cycle of a 0x55 write
    bus.io_wr_valid = 1'b1;
    bus.io_wr_addr  = 1'b0;
    bus.io_wr_data  = 8'h55;
    @(posedge clk); #1;
    bus.io_wr_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("rstw_enbus", {30'd0, bus.io_ENbus}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rstw_bank0",     {24'd0, bus.io_Qbus_0}, 32'h99);
    check("rstw_dbus",      {24'd0, bus.io_Dbus}, 32'h00);
    check("rstw_count",     {24'd0, bus.io_wr_count}, 32'd0);
    check("rstw_out_bits",  {24'd0, bus.io_out_bits}, 32'h00);
    check("rstw_out_valid", {31'd0, bus.io_out_valid}, 32'd0);
    check("rstw_busy",      {31'd0, bus.io_busy}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rstw_wr_ready", {31'd0, bus.io_wr_ready}, 32'd1);
    check("rstw_enbus2",   {30'd0, bus.io_ENbus}, 32'd0);
    @(posedge clk); #1;
    check("rstw_bank0_after", {24'd0, bus.io_Qbus_0}, 32'h99);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
